// File: rtl/fetch_stage.sv
// fetch_stage: LEGv8 instruction fetch with PC, ROM addressing and IF/ID register.
// Optional halt-on-self-loop (CBZ to self) detection enabled by FETCH_HALT_DETECT_EN.
module fetch_stage #(
    parameter int N      = 64,
    parameter int ADDR_W = 6,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_q,
    input  logic              stall_D,
    input  logic              PCSrc_E,
    input  logic [N-1:0]      PCBranch_E,
    output logic [N-1:0]      PC_D,
    output logic [INST_W-1:0] instr_D,
    output logic              valid_D,
    output logic              halted
);
    logic [N-1:0]      pc_q, pc_d, pc_d_q, pc_d_d;
    logic [INST_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d, halt_q, halt_d, is_halt;

`ifdef FETCH_HALT_DETECT_EN
    assign is_halt = imem_q[31:24] == 8'hB4 && imem_q[23:5] == '0;
    assign halted  = halt_q;
`else
    assign is_halt = 1'b0;
    assign halted  = 1'b0;
`endif

    assign imem_addr = pc_q[ADDR_W+1:2];
    assign PC_D      = pc_d_q;
    assign instr_D   = instr_q;
    assign valid_D   = valid_q;

    // Priority: redirect > stall > halted > normal fetch.
    always_comb begin
        pc_d    = pc_q;
        pc_d_d  = pc_d_q;
        instr_d = instr_q;
        valid_d = valid_q;
        halt_d  = halt_q;
        if (PCSrc_E) begin
            pc_d    = {PCBranch_E[N-1:2], 2'b00};
            pc_d_d  = '0;
            instr_d = '0;
            valid_d = 1'b0;
            halt_d  = 1'b0;
        end else if (!stall_D) begin
            if (halt_q) begin
                valid_d = 1'b0;
            end else begin
                pc_d_d  = pc_q;
                instr_d = imem_q;
                valid_d = 1'b1;
                halt_d  = is_halt;
                pc_d    = is_halt ? pc_q : pc_q + N'(4);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= '0;
            pc_d_q  <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            pc_d_q  <= pc_d_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            halt_q  <= halt_d;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus with a per-cycle reference model of the fetch rules.
module tb_fetch_stage;
    logic        clk = 0, reset = 1, stall_D = 0, PCSrc_E = 0;
    logic [63:0] PCBranch_E = '0;
    logic [5:0]  imem_addr;
    logic [31:0] imem_q, instr_D;
    logic [63:0] PC_D;
    logic        valid_D, halted;
    logic [31:0] rom [64];
    int          vectors = 0, miscompares = 0;

    logic [63:0] m_pc = 0, m_pcd = 0;
    logic [31:0] m_ins = 0, w;
    logic        m_val = 0, m_halt = 0;
`ifdef FETCH_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    fetch_stage dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_q(imem_q),
        .stall_D(stall_D), .PCSrc_E(PCSrc_E), .PCBranch_E(PCBranch_E),
        .PC_D(PC_D), .instr_D(instr_D), .valid_D(valid_D), .halted(halted)
    );

    assign imem_q = rom[imem_addr];
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the word fetched is rom[(pc/4) mod 64].
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc = 0; m_pcd = 0; m_ins = 0; m_val = 0; m_halt = 0;
        end else if (PCSrc_E) begin
            m_pc = PCBranch_E - (PCBranch_E % 4); m_pcd = 0; m_ins = 0; m_val = 0; m_halt = 0;
        end else if (!stall_D) begin
            if (m_halt) m_val = 0;
            else begin
                w = rom[(m_pc / 4) % 64];
                m_pcd = m_pc; m_ins = w; m_val = 1;
                if (HALT_EN && (w >> 5) == (32'hB4000000 >> 5)) m_halt = 1;
                else m_pc = m_pc + 4;
            end
        end
    end

    always @(negedge clk) begin
        chk("imem_addr", 64'(imem_addr), (m_pc / 4) % 64);
        chk("PC_D", PC_D, m_pcd);
        chk("instr_D", 64'(instr_D), 64'(m_ins));
        chk("valid_D", 64'(valid_D), 64'(m_val));
        chk("halted", 64'(halted), 64'(m_halt));
    end

    task automatic step(input logic s, input logic p, input logic [63:0] t);
        stall_D = s; PCSrc_E = p; PCBranch_E = t;
        @(posedge clk); #1;
        stall_D = 0; PCSrc_E = 0; PCBranch_E = '0;
    endtask

    task automatic lit(input string nm, input logic [63:0] pcd, input logic [31:0] ins, input logic v);
        chk({nm, ".PC_D"}, PC_D, pcd);
        chk({nm, ".instr_D"}, 64'(instr_D), 64'(ins));
        chk({nm, ".valid_D"}, 64'(valid_D), 64'(v));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'h91000000 | i;
        rom[0] = 32'h8b000002; rom[1] = 32'h8b000003; rom[2] = 32'hb40000de;
        rom[18] = 32'hb4000000;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        lit("reset", 0, 0, 0);
        chk("reset.halted", 64'(halted), 0);
        step(0, 0, 0); lit("seq0", 0, 32'h8b000002, 1);
        step(0, 0, 0); lit("seq1", 4, 32'h8b000003, 1);
        step(0, 0, 0); lit("seq2", 8, 32'hb40000de, 1);
        chk("seq.addr", 64'(imem_addr), 3);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0); lit("stall", 8, 32'hb40000de, 1);
        end
        step(0, 0, 0); lit("resume", 64'hC, 32'h91000003, 1);
        step(0, 1, 64'h1F); lit("redir.bubble", 0, 0, 0);
        chk("redir.addr", 64'(imem_addr), 7);
        step(0, 0, 0); lit("redir.target", 64'h1C, 32'h91000007, 1);
        step(1, 1, 64'h40); lit("stallredir.bubble", 0, 0, 0);
        step(0, 0, 0); lit("stallredir.target", 64'h40, 32'h91000010, 1);
        step(0, 1, 64'hFC); lit("wrap.bubble", 0, 0, 0);
        step(0, 0, 0); lit("wrap.63", 64'hFC, 32'h9100003F, 1);
        step(0, 0, 0); lit("wrap.0", 64'h100, 32'h8b000002, 1);
        step(0, 1, 64'h48); lit("halt.bubble", 0, 0, 0);
        step(0, 0, 0); lit("halt.capture", 64'h48, 32'hb4000000, 1);
`ifdef FETCH_HALT_DETECT_EN
        chk("halt.flag", 64'(halted), 1);
        chk("halt.addr", 64'(imem_addr), 18);
        step(0, 0, 0); lit("halt.idle1", 64'h48, 32'hb4000000, 0);
        step(0, 0, 0); lit("halt.idle2", 64'h48, 32'hb4000000, 0);
        chk("halt.addr2", 64'(imem_addr), 18);
        step(0, 1, 64'h20); lit("halt.redir", 0, 0, 0);
        chk("halt.cleared", 64'(halted), 0);
        step(0, 1, 64'h48); step(0, 0, 0);
        chk("halt.again", 64'(halted), 1);
`else
        chk("nohalt.flag", 64'(halted), 0);
        chk("nohalt.addr", 64'(imem_addr), 19);
        step(0, 0, 0); lit("nohalt.next", 64'h4C, 32'h91000013, 1);
`endif
        #2 reset = 1;
        #1;
        lit("async", 0, 0, 0);
        chk("async.halted", 64'(halted), 0);
        chk("async.addr", 64'(imem_addr), 0);
        @(negedge clk); reset = 0;
        step(0, 0, 0); lit("post_reset", 0, 32'h8b000002, 1);
        step(0, 0, 0); step(0, 0, 0);
        @(negedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
